no_brdr_ctrl_unit: RTL and testbench

Control unit that sequences one frame through the no-border 2-D filter path: the row-buffer/mask stage feeding the filter function. It accepts a pixel stream with a valid/ready handshake and forwards each pixel as a one-cycle ctrl2buf_valid strobe with data_cu2bufcf. It tracks row/column position and asserts en_funct only for pixels whose MASK_WIDTH x MASK_WIDTH window lies fully inside the image (no border padding). It counts pix_valid returns from the filter function and flags frame completion.

---
 rtl/no_brdr_pkg.sv | 32 +++
 rtl/no_brdr_pos_cnt.sv | 58 +++++
 rtl/no_brdr_ctrl_unit.sv | 143 ++++++++++++++
 tb/tb_no_brdr_ctrl_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/no_brdr_pkg.sv
// rtl/no_brdr_pkg.sv - shared types, constants and helpers for the no-border filter control unit

package no_brdr_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int STROBE_W   = 1;
   localparam int EN_FUNCT_W = 1;

   // Never returns less than 1 so that derived vectors are always legal.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int n_out_f(input int row_width, input int col_height, input int mask_width);
      return (row_width - mask_width + 1) * (col_height - mask_width + 1);
   endfunction

   localparam int N_OUT = n_out_f(8, 6, 3);

endpackage

// File: rtl/no_brdr_pos_cnt.sv
// rtl/no_brdr_pos_cnt.sv - column/row position counter with window and frame-end flags

module no_brdr_pos_cnt
   import no_brdr_pkg::*;
#(
   parameter int ROW_WIDTH  = 8,
   parameter int COL_HEIGHT = 6,
   parameter int MASK_WIDTH = 3
)
(
   input  logic clk,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic last_col_o,
   output logic last_pix_o,
   output logic win_ok_o,
   output logic fill_end_o
);

   localparam int CW = clog2(ROW_WIDTH);
   localparam int RW = clog2(COL_HEIGHT);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   assign last_col_o = (col_q == CW'(ROW_WIDTH - 1));
   assign last_pix_o = last_col_o && (row_q == RW'(COL_HEIGHT - 1));
   assign win_ok_o   = (col_q >= CW'(MASK_WIDTH - 1)) && (row_q >= RW'(MASK_WIDTH - 1));
   assign fill_end_o = (col_q == CW'(MASK_WIDTH - 1)) && (row_q == RW'(MASK_WIDTH - 1));

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i || (inc_i && last_pix_o)) begin
         col_d = '0;
         row_d = '0;
      end else if (inc_i) begin
         if (last_col_o) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/no_brdr_ctrl_unit.sv
// rtl/no_brdr_ctrl_unit.sv - frame sequencer for the no-border row-buffer/filter path

module no_brdr_ctrl_unit
   import no_brdr_pkg::*;
#(
   parameter int ROW_WIDTH  = 8,
   parameter int COL_HEIGHT = 6,
   parameter int PIX_BIT    = 8,
   parameter int DATA_BIT   = 8,
   parameter int MASK_WIDTH = 3,
   parameter int FUNCT_LAT  = 4
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   input  logic [PIX_BIT-1:0]  in_pix,
   output logic                in_ready,
   output logic                ctrl2buf_valid,
   output logic [DATA_BIT-1:0] data_cu2bufcf,
   output logic                en_funct,
   input  logic                pix_valid,
   output logic                busy,
   output logic                frame_done,
   output logic                err
);

   localparam int NO     = n_out_f(ROW_WIDTH, COL_HEIGHT, MASK_WIDTH);
   localparam int CNT_W  = clog2(NO + 1);
   localparam int WD_W   = clog2(FUNCT_LAT + 2);
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(FUNCT_LAT + 1);

   state_t state_q, state_d;

   logic                  accept, start_go, pv_bad, wd_expire;
   logic                  last_col, last_pix, win_ok, fill_end, frame_end;
   logic [STROBE_W-1:0]   strb_q, strb_d;
   logic [EN_FUNCT_W-1:0] en_q, en_d;
   logic [DATA_BIT-1:0]   data_q, data_d;
   logic [CNT_W-1:0]      exp_cnt_q, exp_cnt_d, ret_cnt_q, ret_cnt_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic                  err_q, err_d;

   assign accept    = in_valid && in_ready;
   assign start_go  = start && (state_q == IDLE);
   assign frame_end = accept && last_col && last_pix;
   assign pv_bad    = pix_valid && ((state_q == IDLE) || (ret_cnt_q == exp_cnt_q));
   // Watchdog fires on the (FUNCT_LAT+2)-th consecutive DRAIN cycle without a return.
   assign wd_expire = (state_q == DRAIN) && !pix_valid && (ret_cnt_q < CNT_W'(NO)) && (wd_q == WD_LIM);

   no_brdr_pos_cnt #(
      .ROW_WIDTH  (ROW_WIDTH),
      .COL_HEIGHT (COL_HEIGHT),
      .MASK_WIDTH (MASK_WIDTH)
   ) u_pos_cnt (
      .clk        (clk),
      .rst_i      (reset),
      .inc_i      (accept),
      .clr_i      (start_go),
      .last_col_o (last_col),
      .last_pix_o (last_pix),
      .win_ok_o   (win_ok),
      .fill_end_o (fill_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_go) state_d = FILL;
         FILL:    if (frame_end) state_d = DRAIN;
                  else if (accept && fill_end) state_d = RUN;
         RUN:     if (frame_end) state_d = DRAIN;
         DRAIN:   if ((ret_cnt_q == CNT_W'(NO)) || wd_expire) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_q)
         IDLE:      busy = 1'b0;
         FILL, RUN: in_ready = 1'b1;
         DONE:      frame_done = 1'b1;
         default:   ;
      endcase
   end

   always_comb begin
      strb_d    = STROBE_W'(accept);
      en_d      = EN_FUNCT_W'(accept && win_ok);
      data_d    = accept ? DATA_BIT'(in_pix) : data_q;
      exp_cnt_d = exp_cnt_q;
      ret_cnt_d = ret_cnt_q;
      if (start_go) begin
         exp_cnt_d = '0;
         ret_cnt_d = '0;
      end else begin
         if (en_q[0]) exp_cnt_d = exp_cnt_q + 1'b1;
         if (pix_valid && !pv_bad) ret_cnt_d = ret_cnt_q + 1'b1;
      end
      wd_d = '0;
      if ((state_q == DRAIN) && !pix_valid && (wd_q != WD_LIM)) wd_d = wd_q + 1'b1;
      err_d = start_go ? 1'b0 : (err_q | pv_bad | wd_expire);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         strb_q    <= '0;
         en_q      <= '0;
         data_q    <= '0;
         exp_cnt_q <= '0;
         ret_cnt_q <= '0;
         wd_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         strb_q    <= strb_d;
         en_q      <= en_d;
         data_q    <= data_d;
         exp_cnt_q <= exp_cnt_d;
         ret_cnt_q <= ret_cnt_d;
         wd_q      <= wd_d;
         err_q     <= err_d;
      end
   end

   assign ctrl2buf_valid = strb_q[0];
   assign en_funct       = en_q[0];
   assign data_cu2bufcf  = data_q;
   assign err            = err_q;

endmodule

// File: tb/tb_no_brdr_ctrl_unit.sv
// tb/tb_no_brdr_ctrl_unit.sv - scoreboard bench for no_brdr_ctrl_unit

module tb_no_brdr_ctrl_unit;

   localparam int ROW_WIDTH  = 8;
   localparam int COL_HEIGHT = 6;
   localparam int PIX_BIT    = 8;
   localparam int DATA_BIT   = 8;
   localparam int MASK_WIDTH = 3;
   localparam int FUNCT_LAT  = 4;
   localparam int NPIX       = 48;
   localparam int NEXP       = 24;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic                in_valid = 1'b0;
   logic [PIX_BIT-1:0]  in_pix = '0;
   logic                pix_valid = 1'b0;
   logic                in_ready, ctrl2buf_valid, en_funct, busy, frame_done, err;
   logic [DATA_BIT-1:0] data_cu2bufcf;

   typedef struct {
      logic [DATA_BIT-1:0] d;
      logic                en;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   en_seen = 0;
   int   done_seen = 0;
   int   ret_issued = 0;
   int   ret_limit = 1000;
   int   cyc = 0;
   int   last_pv_cyc = 0;
   logic inject_req = 1'b0;
   logic [FUNCT_LAT:0] pv_pipe = '0;

   no_brdr_ctrl_unit #(
      .ROW_WIDTH (ROW_WIDTH), .COL_HEIGHT (COL_HEIGHT), .PIX_BIT (PIX_BIT),
      .DATA_BIT (DATA_BIT), .MASK_WIDTH (MASK_WIDTH), .FUNCT_LAT (FUNCT_LAT)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .in_valid (in_valid), .in_pix (in_pix),
      .in_ready (in_ready), .ctrl2buf_valid (ctrl2buf_valid), .data_cu2bufcf (data_cu2bufcf),
      .en_funct (en_funct), .pix_valid (pix_valid), .busy (busy), .frame_done (frame_done), .err (err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, req);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: event seen, none required", name);
   endtask

   // Monitor: pops one expectation per buffer strobe.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (frame_done) done_seen++;
            if (en_funct) en_seen++;
            if (ctrl2buf_valid) begin
               if (exp_q.size() == 0) fail_now("unexpected_strobe");
               else begin
                  e = exp_q.pop_front();
                  check("data_cu2bufcf", 32'(data_cu2bufcf), 32'(e.d));
                  check("en_funct", 32'(en_funct), 32'(e.en));
               end
            end else if (en_funct) begin
               fail_now("en_funct_without_strobe");
            end
         end
      end
   end

   // Filter-function model: returns pix_valid FUNCT_LAT cycles after en_funct.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         pv_pipe   = '0;
         pix_valid = 1'b0;
      end else begin
         pv_pipe   = {pv_pipe[FUNCT_LAT-1:0], en_funct};
         pix_valid = 1'b0;
         if (inject_req) begin
            pix_valid  = 1'b1;
            inject_req = 1'b0;
         end else if (pv_pipe[FUNCT_LAT] && (ret_issued < ret_limit)) begin
            pix_valid   = 1'b1;
            ret_issued  = ret_issued + 1;
            last_pv_cyc = cyc;
         end
      end
   end

   task automatic run_frame(input int gap_pct, input int reset_at, input int limit,
                            input int busy_start_at, input logic exp_err, input logic done_start);
      int   idx;
      int   guard;
      int   en_base;
      int   done_base;
      exp_t e;
      idx        = 0;
      ret_issued = 0;
      ret_limit  = limit;
      en_base    = en_seen;
      done_base  = done_seen;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("err_cleared_by_start", 32'(err), 32'd0);
      guard = 0;
      while ((idx < NPIX) && (guard < 2000)) begin
         guard++;
         if (idx == reset_at) begin
            in_valid = 1'b0;
            start    = 1'b0;
            @(posedge clk);
            #2 reset = 1'b1;
            exp_q.delete();
            #1;
            check("rst_ctrl2buf_valid", 32'(ctrl2buf_valid), 32'd0);
            check("rst_en_funct", 32'(en_funct), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_data", 32'(data_cu2bufcf), 32'd0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("no_frame_done_after_reset", 32'(done_seen - done_base), 32'd0);
            check("idle_after_reset", 32'(busy), 32'd0);
            return;
         end
         in_valid = ($urandom_range(99) >= gap_pct) ? 1'b1 : 1'b0;
         in_pix   = PIX_BIT'(idx);
         start    = (idx == busy_start_at) ? 1'b1 : 1'b0;
         if (in_valid && in_ready) begin
            e.d  = DATA_BIT'(idx);
            e.en = ((idx / ROW_WIDTH) >= MASK_WIDTH - 1) && ((idx % ROW_WIDTH) >= MASK_WIDTH - 1);
            exp_q.push_back(e);
            idx++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (idx < NPIX) fail_now("pixel_feed_timeout");
      guard = 0;
      while (!frame_done && (guard < 200)) begin
         @(negedge clk);
         guard++;
      end
      if (!frame_done) fail_now("frame_done_timeout");
      if (done_start) start = 1'b1;
      #1;
      check("err_at_done", 32'(err), 32'(exp_err));
      check("en_funct_count", 32'(en_seen - en_base), 32'(NEXP));
      check("frame_done_count", 32'(done_seen - done_base), 32'd1);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      if (limit < NEXP) check("watchdog_delay", 32'(cyc - last_pv_cyc), 32'(FUNCT_LAT + 3));
      if (done_start) begin
         @(negedge clk);
         start = 1'b0;
         check("start_in_done_ignored", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_ctrl2buf_valid", 32'(ctrl2buf_valid), 32'd0);
      check("reset_data", 32'(data_cu2bufcf), 32'd0);
      check("reset_en_funct", 32'(en_funct), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      reset = 1'b0;

      run_frame(0,  -1, 1000, -1, 1'b0, 1'b0);
      run_frame(50, -1, 1000, -1, 1'b0, 1'b0);
      run_frame(0,  30, 1000, -1, 1'b0, 1'b0);
      run_frame(0,  -1, 1000, -1, 1'b0, 1'b0);
      run_frame(0,  -1, 20,   -1, 1'b1, 1'b0);
      run_frame(0,  -1, 1000, -1, 1'b0, 1'b0);

      @(negedge clk);
      inject_req = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_pix_valid_err", 32'(err), 32'd1);
      check("idle_pix_valid_state", 32'(busy), 32'd0);

      run_frame(0,  -1, 1000, 10, 1'b0, 1'b1);
      run_frame(0,  -1, 1000, 30, 1'b0, 1'b0);
      run_frame(30, -1, 1000, -1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
